delay_chain_calib: RTL



---
 rtl/delay_calib_pkg.sv | 12 +
 rtl/delay_chain_calib_if.sv | 12 +
 rtl/delay_chain_calib_thermo_count.sv | 26 ++
 rtl/delay_chain_calib.sv | 115 +++++++++++
 4 files changed

// File: rtl/delay_calib_pkg.sv
// Shared types and constants for the delay-chain calibration controller.
package delay_calib_pkg;

  typedef enum logic [2:0] {IDLE, RSTC, LAUNCH, SETTLE, ACC, DONE} calib_state_t;

  localparam int RSTC_CYCLES = 2;

  function automatic int count_w(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/delay_chain_calib_if.sv
// Request/result handshake between a calibration requester and delay_chain_calib.
interface delay_chain_calib_if #(parameter int CW = 5);
  logic          start;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;
  logic          res_bubble;

  modport master (output start, res_ready, input busy, res_valid, res_count, res_bubble);
  modport slave  (input start, res_ready, output busy, res_valid, res_count, res_bubble);
endinterface

// File: rtl/delay_chain_calib_thermo_count.sv
// Leading-ones count of a thermometer-coded tap vector, flagging any 1 above the first 0.
module thermo_count
  import delay_calib_pkg::*;
#(
  parameter  int TAPS = 16,
  localparam int CW   = count_w(TAPS)
) (
  input  logic [TAPS-1:0] vec,
  output logic [CW-1:0]   cnt,
  output logic            bubble
);

  logic seen_zero;

  always_comb begin
    cnt       = '0;
    bubble    = 1'b0;
    seen_zero = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (!vec[i])        seen_zero = 1'b1;
      else if (seen_zero) bubble    = 1'b1;
      else                cnt       = cnt + CW'(1);
    end
  end

endmodule

// File: rtl/delay_chain_calib.sv
// Delay-chain calibration: reset chain, launch an edge, capture taps, average
// 2^AVG_LOG2 leading-ones counts and return taps per clock period.
module delay_chain_calib
  import delay_calib_pkg::*;
#(
  parameter  int   TAPS        = 16,
  parameter  int   SYNC_STAGES = 2,
  parameter  int   AVG_LOG2    = 2,
  parameter  logic RPOL        = 1'b0,
  localparam int   CW          = count_w(TAPS)
) (
  input  logic                clk,
  input  logic                rst,
  delay_chain_calib_if.slave  rif,
  output logic                chain_rst,
  output logic                chain_i,
  input  logic [TAPS-1:0]     taps
);

  localparam int AW = CW + AVG_LOG2;
  localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PW = $clog2(RSTC_CYCLES + SYNC_STAGES);
  localparam logic [SW-1:0] LAST_SMP = SW'((1 << AVG_LOG2) - 1);

  calib_state_t    state_q, state_d;
  logic [PW-1:0]   ph_q;
  logic [SW-1:0]   smp_q;
  logic [AW-1:0]   acc_q;
  logic            bub_q;
  logic [CW-1:0]   res_count_q;
  logic            res_bubble_q;
  logic [TAPS-1:0] cap_q [SYNC_STAGES];

  logic [CW-1:0]   cnt;
  logic            bubble;
  logic [AW-1:0]   acc_sum;

  thermo_count #(.TAPS(TAPS)) u_thermo (
    .vec    (cap_q[SYNC_STAGES-1]),
    .cnt    (cnt),
    .bubble (bubble)
  );

  assign acc_sum = acc_q + AW'(cnt);

  always_comb begin
    state_d   = state_q;
    chain_rst = RPOL;
    chain_i   = 1'b0;
    case (state_q)
      IDLE:   if (rif.start) state_d = RSTC;
      RSTC:   if (ph_q == PW'(RSTC_CYCLES - 1)) state_d = LAUNCH;
      LAUNCH: begin
        chain_rst = ~RPOL;
        chain_i   = 1'b1;
        state_d   = SETTLE;
      end
      SETTLE: begin
        chain_rst = ~RPOL;
        chain_i   = 1'b1;
        if (ph_q == PW'(SYNC_STAGES - 2)) state_d = ACC;
      end
      ACC: begin
        chain_rst = ~RPOL;
        chain_i   = 1'b1;
        state_d   = (smp_q == LAST_SMP) ? DONE : RSTC;
      end
      DONE:   if (rif.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ph_q         <= '0;
      smp_q        <= '0;
      acc_q        <= '0;
      bub_q        <= 1'b0;
      res_count_q  <= '0;
      res_bubble_q <= 1'b0;
      for (int k = 0; k < SYNC_STAGES; k++) cap_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= (state_d != state_q) ? '0 : ph_q + PW'(1);
      case (state_q)
        IDLE: if (rif.start) begin
          acc_q <= '0;
          smp_q <= '0;
          bub_q <= 1'b0;
        end
        // taps is asynchronous: only this edge samples it, the rest is resync depth
        LAUNCH: cap_q[0] <= taps;
        SETTLE: for (int k = 1; k < SYNC_STAGES; k++) cap_q[k] <= cap_q[k-1];
        ACC: begin
          acc_q <= acc_sum;
          bub_q <= bub_q | bubble;
          if (smp_q == LAST_SMP) begin
            res_count_q  <= CW'(acc_sum >> AVG_LOG2);
            res_bubble_q <= bub_q | bubble;
          end else begin
            smp_q <= smp_q + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rif.busy       = (state_q != IDLE) && (state_q != DONE);
  assign rif.res_valid  = (state_q == DONE);
  assign rif.res_count  = res_count_q;
  assign rif.res_bubble = res_bubble_q;

endmodule
